// File: rtl/life_pkg.sv
// Shared types and constants for the life generation scheduler.
// The state encoding is visible on state_o, so the values are fixed.
package life_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_SEED     = 3'd2,
    S_RUN      = 3'd3,
    S_GEN      = 3'd4,
    S_GEN_STEP = 3'd5
  } sched_state_t;

  localparam int SPEED_MAX = 7;
  localparam int SPEED_W   = $clog2(SPEED_MAX + 1);

  // Wide enough for (TICK_BASE << SPEED_MAX) - 1 with a spare bit.
  function automatic int tick_width(input int tick_base);
    return $clog2(tick_base) + 8;
  endfunction

endpackage

// File: rtl/life_rate_divider.sv
// Generation-rate tick counter: counts while enabled, pulses tc on the last cycle
// of each period, and re-latches the period from speed only when it reloads.
module life_rate_divider
  import life_pkg::*;
#(
  parameter int TICK_BASE = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  output logic               tc
);

  localparam int TICK_W = tick_width(TICK_BASE);

  logic [TICK_W-1:0] count_reg;
  logic [TICK_W-1:0] limit_reg;
  logic [TICK_W-1:0] limit_next;

  always_comb begin
    limit_next = (TICK_W'(TICK_BASE) << speed) - TICK_W'(1);
  end

  assign tc = enable && (count_reg == limit_reg);

  // Holding (neither enable nor clear) keeps the count frozen across a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      limit_reg <= TICK_W'(TICK_BASE - 1);
    end else if (clear || tc) begin
      count_reg <= '0;
      limit_reg <= limit_next;
    end else if (enable) begin
      count_reg <= count_reg + TICK_W'(1);
    end
  end

endmodule

// File: rtl/life_gen_scheduler.sv
// Turns operator controls into clear / seed-fill / generation-advance commands
// for the grid datapath and keeps the generation counter for the display.
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int TICK_BASE   = 1024,
  parameter int SEED_CYCLES = 64,
  parameter int GEN_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               randomize,
  input  logic               step,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  input  logic               gen_ack,
  output logic               grid_clear,
  output logic               seed_load,
  output logic               lfsr_en,
  output logic               gen_req,
  output logic [GEN_W-1:0]   gen_count,
  output logic [2:0]         state_o
);

  localparam int SEED_W = $clog2(SEED_CYCLES) + 1;

  sched_state_t      state_reg;
  sched_state_t      state_next;
  logic              rand_prev_reg;
  logic              rand_edge;
  logic              pend_clear_reg;
  logic              pend_clear_next;
  logic              pend_seed_reg;
  logic              pend_seed_next;
  logic [SEED_W-1:0] seed_cnt_reg;
  logic [SEED_W-1:0] seed_cnt_next;
  logic [GEN_W-1:0]  gen_count_reg;
  logic [GEN_W-1:0]  gen_count_next;
  logic              grid_clear_reg;
  logic              seed_load_reg;
  logic              gen_req_reg;
  logic              tick_tc;
  logic              div_enable;
  logic              div_clear;

  assign rand_edge  = randomize & ~rand_prev_reg;
  assign div_enable = (state_reg == S_RUN);
  assign div_clear  = (state_reg != S_RUN) && (state_reg != S_GEN);

  life_rate_divider #(
    .TICK_BASE (TICK_BASE)
  ) u_rate_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (div_enable),
    .clear  (div_clear),
    .speed  (speed),
    .tc     (tick_tc)
  );

  always_comb begin
    state_next      = state_reg;
    seed_cnt_next   = seed_cnt_reg;
    gen_count_next  = gen_count_reg;
    pend_clear_next = pend_clear_reg;
    pend_seed_next  = pend_seed_reg;

    case (state_reg)
      S_IDLE: begin
        if (clear)          state_next = S_CLEAR;
        else if (rand_edge) state_next = S_SEED;
        else if (step)      state_next = S_GEN_STEP;
        else if (start)     state_next = S_RUN;
      end

      S_CLEAR: begin
        gen_count_next = '0;
        state_next     = start ? S_RUN : S_IDLE;
      end

      S_SEED: begin
        if (seed_cnt_reg == SEED_W'(SEED_CYCLES - 1)) begin
          state_next = start ? S_RUN : S_IDLE;
        end else begin
          seed_cnt_next = seed_cnt_reg + SEED_W'(1);
        end
      end

      S_RUN: begin
        if (clear)          state_next = S_CLEAR;
        else if (rand_edge) state_next = S_SEED;
        else if (!start)    state_next = S_IDLE;
        else if (tick_tc)   state_next = S_GEN;
      end

      S_GEN, S_GEN_STEP: begin
        // Commands arriving mid-handshake are remembered, never aborting it.
        if (clear)     pend_clear_next = 1'b1;
        if (rand_edge) pend_seed_next  = 1'b1;
        if (gen_ack) begin
          gen_count_next  = gen_count_reg + GEN_W'(1);
          pend_clear_next = 1'b0;
          pend_seed_next  = 1'b0;
          if (pend_clear_reg || clear)                 state_next = S_CLEAR;
          else if (pend_seed_reg || rand_edge)         state_next = S_SEED;
          else if ((state_reg == S_GEN) && start)      state_next = S_RUN;
          else                                         state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase

    if ((state_next == S_SEED) && (state_reg != S_SEED)) begin
      gen_count_next = '0;
      seed_cnt_next  = '0;
    end
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      rand_prev_reg  <= 1'b0;
      pend_clear_reg <= 1'b0;
      pend_seed_reg  <= 1'b0;
      seed_cnt_reg   <= '0;
      gen_count_reg  <= '0;
      grid_clear_reg <= 1'b0;
      seed_load_reg  <= 1'b0;
      gen_req_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rand_prev_reg  <= randomize;
      pend_clear_reg <= pend_clear_next;
      pend_seed_reg  <= pend_seed_next;
      seed_cnt_reg   <= seed_cnt_next;
      gen_count_reg  <= gen_count_next;
      grid_clear_reg <= (state_next == S_CLEAR);
      seed_load_reg  <= (state_next == S_SEED);
      gen_req_reg    <= (state_next == S_GEN) || (state_next == S_GEN_STEP);
    end
  end

  assign grid_clear = grid_clear_reg;
  assign seed_load  = seed_load_reg;
  assign lfsr_en    = seed_load_reg;
  assign gen_req    = gen_req_reg;
  assign gen_count  = gen_count_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler with TICK_BASE=4, SEED_CYCLES=8, GEN_W=4:
// an IDLE command-priority table plus hand-written multi-cycle sequences.
module tb_life_gen_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       randomize;
  logic       step;
  logic       clear;
  logic [2:0] speed;
  logic       gen_ack;
  logic       grid_clear;
  logic       seed_load;
  logic       lfsr_en;
  logic       gen_req;
  logic [3:0] gen_count;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  life_gen_scheduler #(
    .TICK_BASE   (4),
    .SEED_CYCLES (8),
    .GEN_W       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .randomize  (randomize),
    .step       (step),
    .clear      (clear),
    .speed      (speed),
    .gen_ack    (gen_ack),
    .grid_clear (grid_clear),
    .seed_load  (seed_load),
    .lfsr_en    (lfsr_en),
    .gen_req    (gen_req),
    .gen_count  (gen_count),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       rnd;
    logic       stp;
    logic       clr;
    logic [2:0] exp_state;
    logic       exp_gclr;
    logic       exp_seed;
    logic       exp_req;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic inputs_idle();
    start     = 1'b0;
    randomize = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    gen_ack   = 1'b0;
  endtask

  task automatic do_reset();
    inputs_idle();
    speed = 3'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (gen_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk(name, int'(gen_req), 1);
  endtask

  // Entered in the cycle gen_req first reads high; acks in cycle r+d.
  task automatic handshake(input int d, input int step_at, input int clear_at, output int high);
    high = 0;
    for (int i = 0; i <= d; i++) begin
      if (gen_req) high++;
      step    = (i == step_at);
      clear   = (i == clear_at);
      gen_ack = (i == d);
      tick();
    end
    step    = 1'b0;
    clear   = 1'b0;
    gen_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int high;
    int cnt_seed;
    int cnt_lfsr;
    int rise;
    int prev_rise;
    int c0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1};

    // Reset state while reset is held.
    inputs_idle();
    speed = 3'd0;
    reset = 1'b1;
    #2;
    chk("rst_state", int'(state_o), 0);
    chk("rst_gen_count", int'(gen_count), 0);
    chk("rst_outputs", int'({grid_clear, seed_load, lfsr_en, gen_req}), 0);

    // IDLE command priority table.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      start     = vecs[i].st;
      randomize = vecs[i].rnd;
      step      = vecs[i].stp;
      clear     = vecs[i].clr;
      tick();
      $display("vec %0d: in st=%0b rnd=%0b stp=%0b clr=%0b -> state=%0d", i,
               vecs[i].st, vecs[i].rnd, vecs[i].stp, vecs[i].clr, state_o);
      chk($sformatf("vec%0d_state", i), int'(state_o), int'(vecs[i].exp_state));
      chk($sformatf("vec%0d_grid_clear", i), int'(grid_clear), int'(vecs[i].exp_gclr));
      chk($sformatf("vec%0d_seed_load", i), int'(seed_load), int'(vecs[i].exp_seed));
      chk($sformatf("vec%0d_lfsr_en", i), int'(lfsr_en), int'(vecs[i].exp_seed));
      chk($sformatf("vec%0d_gen_req", i), int'(gen_req), int'(vecs[i].exp_req));
      inputs_idle();
    end

    // Continuous run, speed 0, ack 2 cycles after each request: period 7, count wraps.
    do_reset();
    start = 1'b1;
    c0 = cyc;
    prev_rise = 0;
    for (int k = 1; k <= 17; k++) begin
      wait_req($sformatf("run_req_seen%0d", k));
      rise = cyc;
      if (k == 1) chk("run_first_rise", rise - c0, 5);
      else        chk($sformatf("run_period%0d", k), rise - prev_rise, 7);
      prev_rise = rise;
      handshake(2, -1, -1, high);
      chk($sformatf("run_req_high%0d", k), high, 3);
      chk($sformatf("run_req_drop%0d", k), int'(gen_req), 0);
      chk($sformatf("run_gen_count%0d", k), int'(gen_count), k % 16);
      $display("gen %0d: rise at cycle %0d, gen_count=%0d", k, rise, gen_count);
    end
    start = 1'b0;
    tick();
    chk("run_stop_state", int'(state_o), 0);
    chk("run_stop_count", int'(gen_count), 1);

    // Seed fill: 8 cycles, counter zeroed, back to IDLE; held randomize does not refire.
    randomize = 1'b1;
    cnt_seed = 0;
    cnt_lfsr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (seed_load) cnt_seed++;
      if (lfsr_en) cnt_lfsr++;
    end
    $display("seed: seed_load cycles=%0d lfsr_en cycles=%0d", cnt_seed, cnt_lfsr);
    chk("seed_len", cnt_seed, 8);
    chk("seed_lfsr_len", cnt_lfsr, 8);
    chk("seed_gen_count", int'(gen_count), 0);
    chk("seed_done_state", int'(state_o), 0);
    cnt_seed = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seed_load) cnt_seed++;
    end
    chk("seed_no_retrigger", cnt_seed, 0);
    randomize = 1'b0;
    tick();

    // Single step with ack in the 10th request cycle; a second step meanwhile is ignored.
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_state", int'(state_o), 5);
    handshake(9, 3, -1, high);
    $display("step: gen_req high %0d cycles, gen_count=%0d", high, gen_count);
    chk("step_req_high", high, 10);
    chk("step_gen_count", int'(gen_count), 1);
    chk("step_done_state", int'(state_o), 0);
    cnt_seed = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gen_req) cnt_seed++;
    end
    chk("step_no_second", cnt_seed, 0);

    // Clear during a run handshake: handshake completes, then one clear strobe.
    do_reset();
    start = 1'b1;
    wait_req("clr_req_seen");
    handshake(4, -1, 1, high);
    $display("clear-in-gen: req high %0d, gen_count=%0d, state=%0d", high, gen_count, state_o);
    chk("clr_req_high", high, 5);
    chk("clr_req_drop", int'(gen_req), 0);
    chk("clr_state", int'(state_o), 1);
    chk("clr_grid_clear", int'(grid_clear), 1);
    tick();
    chk("clr_strobe_end", int'(grid_clear), 0);
    chk("clr_gen_count", int'(gen_count), 0);
    chk("clr_back_run", int'(state_o), 3);
    start = 1'b0;
    tick();

    // Speed 0 -> 2 mid-period: current period 4 cycles, next 16.
    do_reset();
    start = 1'b1;
    c0 = cyc;
    tick();
    tick();
    speed = 3'd2;
    wait_req("spd_req_seen1");
    rise = cyc;
    chk("spd_first_period", rise - c0, 5);
    handshake(0, -1, -1, high);
    wait_req("spd_req_seen2");
    $display("speed: second request %0d cycles after first", cyc - rise);
    chk("spd_second_period", cyc - rise, 17);
    handshake(0, -1, -1, high);
    start = 1'b0;
    speed = 3'd0;
    tick();

    // Reset in the third seed cycle, then a spurious ack in IDLE.
    do_reset();
    randomize = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_seed_active", int'(seed_load), 1);
    randomize = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_async_state", int'(state_o), 0);
    chk("rst_async_outputs", int'({grid_clear, seed_load, lfsr_en, gen_req}), 0);
    #1;
    reset = 1'b0;
    tick();
    gen_ack = 1'b1;
    tick();
    gen_ack = 1'b0;
    tick();
    chk("spurious_ack_count", int'(gen_count), 0);
    chk("spurious_ack_req", int'(gen_req), 0);
    chk("spurious_ack_state", int'(state_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
